mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter and sequencer for the single shared data-memory port of the multicycle CPU. Three requesters (0 = instruction fetch, 1 = load/store unit, 2 = debug/loader) compete for the port. The arbiter drives the 2-bit select of the `Mux3to1` instances that steer address and write data into memory. It also times each fixed-latency access and returns a one-cycle acknowledge to the winner.

## Interface
Parameters:
- `MEM_LATENCY`, default 2: cycles the memory needs with `mem_en` held high; legal range is 1 to 15.
- `CNT_W`, default 4: width of the latency counter; must satisfy 2^`CNT_W` > `MEM_LATENCY`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  3  per-requester access request; bit i belongs to requester i.
- `we`  in  3  per-requester write enable; only the granted bit is used.
- `gnt`  out  3  one-hot grant; all zeros when idle.
- `ack`  out  3  one-hot, one-cycle completion pulse to the granted requester.
- `mux_sel`  out  2  index of the granted requester; drives the address/wdata `Mux3to1` selects and the rdata return routing.
- `mem_en`  out  1  memory access enable.
- `mem_we`  out  1  memory write enable; equals `we[grant index]` during ACCESS, 0 otherwise.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE. All outputs are registered or decoded from the state (Moore).
- IDLE: if any `req` bit is high, pick the winner by round-robin, latch its index into `mux_sel`, load the counter with `MEM_LATENCY-1`, and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: `gnt[mux_sel]`=1, `mem_en`=1, `mem_we`=latched write enable.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, go to DONE.
  - ACCESS therefore lasts exactly `MEM_LATENCY` cycles.
- DONE: `ack[mux_sel]`=1, `gnt[mux_sel]`=1, `mem_en`=0. Memory rdata is valid this cycle and the requester captures it on `ack`. Next state is always IDLE.
- Round-robin pointer `ptr` (values 0..2) marks the highest-priority index.
  - Search order is `ptr`, `ptr+1`, `ptr+2`, all mod 3.
  - On each grant to winner w, set `ptr` ← (w+1) mod 3.
- `we[w]` is latched at grant time. Changes to `we` during ACCESS are ignored.
- Requester protocol:
  - Hold `req`, address and wdata stable from assertion until `ack` is seen.
  - Drop `req` on the clock edge at which `ack` is sampled high.
  - Keeping `req` high past `ack` requests a new access; it re-enters arbitration in the next IDLE cycle.
- If `req[w]` drops during ACCESS, the access still completes and `ack` is still issued. No abort path exists.
- Requests from non-granted requesters are ignored while `busy` is high. They are not queued beyond their own held `req`.
- `mux_sel` holds its last value while IDLE.

## Timing
- Reset values: state=IDLE, `ptr`=0, `mux_sel`=0, counter=0, `gnt`=000, `ack`=000, `mem_en`=0, `mem_we`=0, `busy`=0.
- With `req` sampled high in IDLE at cycle 0:
  - ACCESS occupies cycles 1 through L (L = `MEM_LATENCY`).
  - `ack` is high in cycle L+1.
  - IDLE returns in cycle L+2.
- Minimum spacing between back-to-back accesses is L+2 cycles.
- Simultaneous requests: exactly one grant, decided by `ptr`. The losers wait in later IDLE cycles.
- A reset asserted in any state wins. On the next cycle: IDLE, all outputs at reset values, `ptr`=0. An in-flight access is dropped with no `ack`.
- `MEM_LATENCY`=1: ACCESS lasts one cycle; the counter is loaded with 0.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, DONE);
  - requester index constants `REQ_IFETCH`=0, `REQ_LSU`=1, `REQ_DBG`=2;
  - `NUM_REQ`=3.
- One sub-module, `rr_pick3`: combinational. Takes `req[2:0]` and `ptr[1:0]`; produces `valid` and `win[1:0]`.
- The address, wdata and rdata muxing stay outside this block as existing `Mux3to1`/`Mux2to1` instances driven by `mux_sel`.

## Test plan
- Reset then single request: `req`=010, `we`=010, L=2.
  - `gnt`=010 and `mem_we`=1 in cycles 1–2.
  - `ack`=010 in cycle 3.
  - `mux_sel`=1 from cycle 1; `ptr`=2 afterwards.
- All three requesting continuously (`req`=111), one `ack` consumed each access.
  - Grant order is 0, 1, 2, 0.
  - Each `ack` is spaced 4 cycles apart at L=2.
- Contention after rotation: with `ptr`=2, `req`=011 → requester 0 wins (2 is not requesting, 0 is next), then `ptr`=1.
- Requester 1 drops `req` mid-ACCESS: access runs the full L cycles, `ack`=010 is still issued, then the arbiter returns to IDLE.
- Reset asserted in the first ACCESS cycle: next cycle shows `gnt`=000, `mem_en`=0, `busy`=0, `ptr`=0, and `ack` is never issued.
- MEM_LATENCY=1 build, `req`=100, `we`=000: `mem_en` high for one cycle, `ack`=100 in cycle 2, `mem_we` stays 0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

  localparam int NUM_REQ    = 3;
  localparam int REQ_IFETCH = 0;
  localparam int REQ_LSU    = 1;
  localparam int REQ_DBG    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  // (base + off) mod 3 for base, off in 0..2
  function automatic logic [1:0] idx_add3(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot3(input logic [1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory-side handshake bundle of the shared memory port arbiter.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] we;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] ack;
  logic [1:0]         mux_sel;
  logic               mem_en;
  logic               mem_we;
  logic               busy;

  modport master (
    output req, we,
    input  gnt, ack, mux_sel, mem_en, mem_we, busy
  );

  modport slave (
    input  req, we,
    output gnt, ack, mux_sel, mem_en, mem_we, busy
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Three-way round-robin winner search starting at the priority pointer.
module rr_pick3
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_ptr,
  output logic               o_valid,
  output logic [1:0]         o_win
);

  // Walk from the lowest priority upward so the highest-priority hit is written last.
  always_comb begin
    o_valid = 1'b0;
    o_win   = i_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[idx_add3(i_ptr, 2'(i))]) begin
        o_valid = 1'b1;
        o_win   = idx_add3(i_ptr, 2'(i));
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer for the shared data-memory port.
// state  | meaning
// IDLE   | no access; arbitrate on req, mux_sel holds last winner
// ACCESS | mem_en high for MEM_LATENCY cycles, gnt to winner
// DONE   | one-cycle ack to winner, rdata valid
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.slave  bus
);

  arb_state_t r_state, w_state_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic [1:0]       r_mux_sel, w_mux_sel_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_we_lat, w_we_lat_nxt;

  logic             w_valid;
  logic [1:0]       w_win;

  rr_pick3 u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_win   (w_win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= 2'd0;
      r_mux_sel <= 2'd0;
      r_cnt     <= '0;
      r_we_lat  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_mux_sel <= w_mux_sel_nxt;
      r_cnt     <= w_cnt_nxt;
      r_we_lat  <= w_we_lat_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_mux_sel_nxt = r_mux_sel;
    w_cnt_nxt     = r_cnt;
    w_we_lat_nxt  = r_we_lat;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_nxt   = ACCESS;
          w_mux_sel_nxt = w_win;
          w_ptr_nxt     = idx_add3(w_win, 2'd1);
          w_cnt_nxt     = CNT_W'(MEM_LATENCY - 1);
          w_we_lat_nxt  = bus.we[w_win];
        end
      end
      ACCESS: begin
        if (r_cnt == '0) w_state_nxt = DONE;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the registered state and latched winner.
  always_comb begin
    bus.gnt     = '0;
    bus.ack     = '0;
    bus.mem_en  = 1'b0;
    bus.mem_we  = 1'b0;
    bus.busy    = (r_state != IDLE);
    bus.mux_sel = r_mux_sel;
    if (r_state == ACCESS) begin
      bus.gnt    = onehot3(r_mux_sel);
      bus.mem_en = 1'b1;
      bus.mem_we = r_we_lat;
    end else if (r_state == DONE) begin
      bus.gnt = onehot3(r_mux_sel);
      bus.ack = onehot3(r_mux_sel);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at MEM_LATENCY=2 and MEM_LATENCY=1.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   cyc;
  int   last_ack;

  mem_port_arbiter_if a ();
  mem_port_arbiter_if b ();

  mem_port_arbiter #(.MEM_LATENCY(2), .CNT_W(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (a)
  );

  mem_port_arbiter #(.MEM_LATENCY(1), .CNT_W(4)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_a(input string tag, input logic [2:0] gnt, input logic [2:0] ack,
                       input logic en, input logic we, input logic busy);
    check({tag, ".gnt"},    8'(a.gnt),    8'(gnt));
    check({tag, ".ack"},    8'(a.ack),    8'(ack));
    check({tag, ".mem_en"}, 8'(a.mem_en), 8'(en));
    check({tag, ".mem_we"}, 8'(a.mem_we), 8'(we));
    check({tag, ".busy"},   8'(a.busy),   8'(busy));
  endtask

  task automatic chk_b(input string tag, input logic [2:0] gnt, input logic [2:0] ack,
                       input logic en, input logic we, input logic busy);
    check({tag, ".gnt"},    8'(b.gnt),    8'(gnt));
    check({tag, ".ack"},    8'(b.ack),    8'(ack));
    check({tag, ".mem_en"}, 8'(b.mem_en), 8'(en));
    check({tag, ".mem_we"}, 8'(b.mem_we), 8'(we));
    check({tag, ".busy"},   8'(b.busy),   8'(busy));
  endtask

  initial begin
    logic [1:0] exp_win [4];
    logic [2:0] we_pat;
    n_checks = 0;
    n_pass   = 0;
    last_ack = 0;
    exp_win  = '{2'd0, 2'd1, 2'd2, 2'd0};
    a.req = '0; a.we = '0;
    b.req = '0; b.we = '0;
    reset = 1'b1;

    // reset values
    tick(); tick();
    reset = 1'b0;
    chk_a("rst", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    check("rst.mux_sel", 8'(a.mux_sel), 8'd0);
    check("rst.ptr", 8'(u_dut.r_ptr), 8'd0);
    chk_b("rst1", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    // single LSU write, L=2
    a.req = 3'b010; a.we = 3'b010;
    tick();
    chk_a("s.c1", 3'b010, 3'b000, 1'b1, 1'b1, 1'b1);
    check("s.c1.mux_sel", 8'(a.mux_sel), 8'd1);
    a.we = 3'b000;
    tick();
    chk_a("s.c2", 3'b010, 3'b000, 1'b1, 1'b1, 1'b1);
    tick();
    chk_a("s.c3", 3'b010, 3'b010, 1'b0, 1'b0, 1'b1);
    a.req = 3'b000;
    tick();
    chk_a("s.c4", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    check("s.c4.mux_sel", 8'(a.mux_sel), 8'd1);
    check("s.ptr", 8'(u_dut.r_ptr), 8'd2);

    // contention with ptr=2: req=011 -> 0 wins
    a.req = 3'b011; a.we = 3'b001;
    tick();
    chk_a("c.c1", 3'b001, 3'b000, 1'b1, 1'b1, 1'b1);
    check("c.mux_sel", 8'(a.mux_sel), 8'd0);
    check("c.ptr", 8'(u_dut.r_ptr), 8'd1);
    tick(); tick();
    chk_a("c.c3", 3'b001, 3'b001, 1'b0, 1'b0, 1'b1);
    a.req = 3'b010; a.we = 3'b000;
    tick();
    chk_a("c.c4", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    // loser LSU now wins, then drops req mid-ACCESS
    tick();
    chk_a("d.c1", 3'b010, 3'b000, 1'b1, 1'b0, 1'b1);
    check("d.ptr", 8'(u_dut.r_ptr), 8'd2);
    a.req = 3'b000;
    tick();
    chk_a("d.c2", 3'b010, 3'b000, 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("d.c3", 3'b010, 3'b010, 1'b0, 1'b0, 1'b1);
    tick();
    chk_a("d.c4", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_a("d.c5", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    // reset in first ACCESS cycle drops the access
    a.req = 3'b001;
    tick();
    chk_a("r.c1", 3'b001, 3'b000, 1'b1, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    chk_a("r.c2", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    check("r.ptr", 8'(u_dut.r_ptr), 8'd0);
    check("r.mux_sel", 8'(a.mux_sel), 8'd0);
    reset = 1'b0;
    a.req = 3'b000;
    tick();
    chk_a("r.c3", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    chk_a("r.c4", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    // all three requesting continuously: order 0,1,2,0, acks 4 cycles apart
    we_pat = 3'b101;
    a.req = 3'b111; a.we = we_pat;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rr%0d.gnt", k), 8'(a.gnt), 8'(3'b001 << exp_win[k]));
      check($sformatf("rr%0d.mem_we", k), 8'(a.mem_we), 8'(we_pat[exp_win[k]]));
      tick(); tick();
      check($sformatf("rr%0d.ack", k), 8'(a.ack), 8'(3'b001 << exp_win[k]));
      if (k > 0) check($sformatf("rr%0d.spacing", k), 8'(cyc - last_ack), 8'd4);
      last_ack = cyc;
      tick();
      check($sformatf("rr%0d.busy", k), 8'(a.busy), 8'd0);
    end
    a.req = 3'b000; a.we = 3'b000;
    check("rr.ptr", 8'(u_dut.r_ptr), 8'd1);

    // MEM_LATENCY=1 build, debug read
    b.req = 3'b100; b.we = 3'b000;
    tick();
    chk_b("l1.c1", 3'b100, 3'b000, 1'b1, 1'b0, 1'b1);
    check("l1.mux_sel", 8'(b.mux_sel), 8'd2);
    tick();
    chk_b("l1.c2", 3'b100, 3'b100, 1'b0, 1'b0, 1'b1);
    b.req = 3'b000;
    tick();
    chk_b("l1.c3", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    check("l1.ptr", 8'(u_dut1.r_ptr), 8'd0);
    chk_a("l1.idle_a", 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
